// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Collects a three-byte command (A, B, opcode) from the receive stream,
// presents it to the shared ALU, captures result and flags, and returns
// them as two bytes on a valid/ready transmit interface.
module alu_cmd_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int OP_WIDTH       = 6,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_valid,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   output logic [OP_WIDTH-1:0]   o_alu_op,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [2:0]            i_alu_flags,
   output logic                  o_busy,
   output logic                  o_drop,
   output logic                  o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      SEND_RES,
      SEND_FLG
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      tmo_cnt;
   logic                  tmo_hit;
   logic                  rx_accept;
   logic                  in_collect;
   logic                  in_respond;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic [DATA_WIDTH-1:0] flg_q;

   // Opcodes the ALU implements; any other byte (including one with bits
   // set above the opcode field) is answered with an error response.
   function automatic logic op_is_valid(input logic [DATA_WIDTH-1:0] b);
      logic ok;
      case (b)
         DATA_WIDTH'(8'h20), DATA_WIDTH'(8'h22), DATA_WIDTH'(8'h24),
         DATA_WIDTH'(8'h25), DATA_WIDTH'(8'h26), DATA_WIDTH'(8'h27),
         DATA_WIDTH'(8'h03), DATA_WIDTH'(8'h02): ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign in_collect = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
   assign in_respond = (state == EXEC) || (state == SEND_RES) || (state == SEND_FLG);
   assign rx_accept  = i_rx_valid && in_collect;

   assign o_busy     = (state != WAIT_A);
   assign o_tx_valid = (state == SEND_RES) || (state == SEND_FLG);

   // Response byte mux: result first, then flags; zero when not sending.
   always_comb begin
      o_tx_data = '0;
      if (state == SEND_RES)
         o_tx_data = res_q;
      else if (state == SEND_FLG)
         o_tx_data = flg_q;
   end

   // Next-state logic; a byte arriving on the expiry cycle wins over timeout.
   always_comb begin
      state_nxt = state;
      tmo_hit   = 1'b0;
      case (state)
         WAIT_A: begin
            if (i_rx_valid) state_nxt = WAIT_B;
         end
         WAIT_B: begin
            if (i_rx_valid) begin
               state_nxt = WAIT_OP;
            end else if (tmo_cnt == CNT_LAST) begin
               state_nxt = WAIT_A;
               tmo_hit   = 1'b1;
            end
         end
         WAIT_OP: begin
            if (i_rx_valid) begin
               state_nxt = EXEC;
            end else if (tmo_cnt == CNT_LAST) begin
               state_nxt = WAIT_A;
               tmo_hit   = 1'b1;
            end
         end
         EXEC: begin
            state_nxt = SEND_RES;
         end
         SEND_RES: begin
            if (i_tx_ready) state_nxt = SEND_FLG;
         end
         SEND_FLG: begin
            if (i_tx_ready) state_nxt = WAIT_A;
         end
         default: begin
            state_nxt = WAIT_A;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= WAIT_A;
      else          state <= state_nxt;
   end

   // Operand/opcode capture; values persist after the command for display.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_alu_a  <= '0;
         o_alu_b  <= '0;
         o_alu_op <= '0;
         err_q    <= 1'b0;
      end else if (rx_accept) begin
         case (state)
            WAIT_A: o_alu_a <= i_rx_data;
            WAIT_B: o_alu_b <= i_rx_data;
            WAIT_OP: begin
               if (op_is_valid(i_rx_data)) begin
                  o_alu_op <= i_rx_data[OP_WIDTH-1:0];
                  err_q    <= 1'b0;
               end else begin
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Result/flag capture during the single execute cycle.
   always_ff @(posedge i_clk) begin
      if (state == EXEC) begin
         if (err_q) begin
            res_q <= '0;
            flg_q <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            res_q <= i_alu_result;
            flg_q <= DATA_WIDTH'(i_alu_flags);
         end
      end
   end

   // Inter-byte gap counter: runs only while a command is partially received.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         tmo_cnt <= '0;
      else if ((state == WAIT_B || state == WAIT_OP) && !i_rx_valid && !tmo_hit)
         tmo_cnt <= tmo_cnt + 1'b1;
      else
         tmo_cnt <= '0;
   end

   // One-cycle status pulses for discarded bytes and abandoned commands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_drop    <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_drop    <= i_rx_valid && in_respond;
         o_timeout <= tmo_hit;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU and a
// scoreboard queue of expected response bytes.
module tb_alu_cmd_sequencer;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready;
   logic [7:0] o_alu_a;
   logic [7:0] o_alu_b;
   logic [5:0] o_alu_op;
   logic [7:0] i_alu_result;
   logic [2:0] i_alu_flags;
   logic       o_busy;
   logic       o_drop;
   logic       o_timeout;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   alu_cmd_sequencer #(
      .DATA_WIDTH(8),
      .OP_WIDTH(6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_alu_op     (o_alu_op),
      .i_alu_result (i_alu_result),
      .i_alu_flags  (i_alu_flags),
      .o_busy       (o_busy),
      .o_drop       (o_drop),
      .o_timeout    (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural ALU: returns {result, 5'b0, negative, zero, carry}.
   function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic [8:0] r;
      case (op)
         6'h20:   r = {1'b0, a} + {1'b0, b};
         6'h22:   r = {1'b0, a} + {1'b0, ~b} + 9'd1;
         6'h24:   r = {1'b0, a & b};
         6'h25:   r = {1'b0, a | b};
         6'h26:   r = {1'b0, a ^ b};
         6'h27:   r = {1'b0, ~(a | b)};
         6'h03:   r = {1'b0, 8'($signed(a) >>> b[2:0])};
         6'h02:   r = {1'b0, a >> b[2:0]};
         default: r = 9'd0;
      endcase
      return {r[7:0], 5'b0, r[7], (r[7:0] == 8'h00), r[8]};
   endfunction

   logic [15:0] alu_out;
   assign alu_out      = alu_fn(o_alu_a, o_alu_b, o_alu_op);
   assign i_alu_result = alu_out[15:8];
   assign i_alu_flags  = alu_out[2:0];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the byte is taken at the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((o_busy || exp_q.size() != 0) && k < 100) begin
         @(negedge i_clk);
         k++;
      end
      check(tag, (k < 100), 1);
   endtask

   // Scoreboard: every accepted tx byte must match the oldest expectation.
   always @(negedge i_clk) begin
      if (i_rst_n && o_tx_valid && i_tx_ready) begin
         check("tx_pending", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0)
            check("tx_byte", o_tx_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int first;
      i_rst_n    = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      i_tx_ready = 1'b1;
      repeat (3) @(negedge i_clk);
      check("rst_alu_a", o_alu_a, 0);
      check("rst_alu_b", o_alu_b, 0);
      check("rst_alu_op", o_alu_op, 0);
      check("rst_tx_valid", o_tx_valid, 0);
      check("rst_tx_data", o_tx_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_drop", o_drop, 0);
      check("rst_timeout", o_timeout, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // ADD 5+3, check operands and response latency
      exp_q.push_back(8'h08); exp_q.push_back(8'h00);
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
      check("add_exec_no_valid", o_tx_valid, 0);
      check("add_busy", o_busy, 1);
      check("add_a", o_alu_a, 8'h05);
      check("add_b", o_alu_b, 8'h03);
      check("add_op", o_alu_op, 6'h20);
      @(negedge i_clk);
      check("add_valid_t2", o_tx_valid, 1);
      wait_idle("add_done");

      // SUB 1-2 followed immediately by AND as a back-to-back command
      exp_q.push_back(8'hFF); exp_q.push_back(8'h04);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h22);
      repeat (3) @(negedge i_clk);
      check("b2b_idle_t4", o_busy, 0);
      exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      send_byte(8'h07);
      check("b2b_a_taken", o_alu_a, 8'h07);
      send_byte(8'h09); send_byte(8'h24);
      wait_idle("b2b_done");

      // Invalid opcode: error response, opcode register untouched
      exp_q.push_back(8'h00); exp_q.push_back(8'h80);
      send_byte(8'h10); send_byte(8'h10); send_byte(8'h3F);
      check("bad_op_kept", o_alu_op, 6'h24);
      check("bad_a", o_alu_a, 8'h10);
      wait_idle("bad_done");

      // Stalled transmitter with bytes arriving during the response
      i_tx_ready = 1'b0;
      exp_q.push_back(8'h10); exp_q.push_back(8'h00);
      send_byte(8'h0F); send_byte(8'h01); send_byte(8'h20);
      @(negedge i_clk);
      for (int i = 0; i < 5; i++) begin
         i_rx_data  = 8'hAA;
         i_rx_valid = 1'b1;
         @(negedge i_clk);
         i_rx_valid = 1'b0;
         check("stall_drop", o_drop, 1);
         check("stall_valid", o_tx_valid, 1);
         check("stall_data", o_tx_data, 8'h10);
         @(negedge i_clk);
         check("stall_drop_end", o_drop, 0);
      end
      check("stall_a_kept", o_alu_a, 8'h0F);
      @(posedge i_clk);
      #1 i_tx_ready = 1'b1;
      wait_idle("stall_done");

      // Timeout after operand A only
      send_byte(8'h33);
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge i_clk);
         if (o_timeout) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      check("tmo_pulses", pulses, 1);
      check("tmo_cycle", first, 16);
      check("tmo_idle", o_busy, 0);
      check("tmo_a_kept", o_alu_a, 8'h33);
      exp_q.push_back(8'h04); exp_q.push_back(8'h00);
      send_byte(8'h02); send_byte(8'h02); send_byte(8'h20);
      wait_idle("tmo_fresh_done");

      // Byte arriving on the expiry cycle is accepted
      send_byte(8'h03);
      repeat (15) @(negedge i_clk);
      send_byte(8'h04);
      check("edge_no_tmo", o_timeout, 0);
      check("edge_busy", o_busy, 1);
      check("edge_b", o_alu_b, 8'h04);
      exp_q.push_back(8'h07); exp_q.push_back(8'h00);
      send_byte(8'h25);
      wait_idle("edge_done");

      // Reset asserted while the flags byte is pending
      exp_q.push_back(8'h01);
      send_byte(8'h09); send_byte(8'h08); send_byte(8'h26);
      @(negedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst_n    = 1'b0;
      i_tx_ready = 1'b0;
      #1;
      check("arst_tx_valid", o_tx_valid, 0);
      check("arst_tx_data", o_tx_data, 0);
      check("arst_a", o_alu_a, 0);
      check("arst_b", o_alu_b, 0);
      check("arst_op", o_alu_op, 0);
      check("arst_busy", o_busy, 0);
      @(negedge i_clk);
      check("arst_sb_empty", exp_q.size(), 0);
      i_rst_n    = 1'b1;
      i_tx_ready = 1'b1;
      exp_q.push_back(8'hF1); exp_q.push_back(8'h04);
      send_byte(8'h0C); send_byte(8'h0A); send_byte(8'h27);
      wait_idle("arst_after_done");

      check("final_sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer that drives the shared ALU from a byte stream instead of switches and buttons. It collects a three-byte command (operand A, operand B, opcode) from the receive side, presents the operands and opcode to the ALU, captures the result and flags, and returns a two-byte response (result, flags) on a valid/ready transmit interface. It sits between the serial receiver/transmitter and the ALU, replacing the button-loaded operand registers.

## Interface

Parameters:
- DATA_WIDTH, 8: operand, result and byte width.
- OP_WIDTH, 6: ALU opcode width.
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap between bytes of one command; minimum 2.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rx_data  in  DATA_WIDTH  received byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid; no backpressure.
- o_tx_data  out  DATA_WIDTH  response byte.
- o_tx_valid  out  1  response byte available.
- i_tx_ready  in  1  transmitter accepts byte when high with o_tx_valid.
- o_alu_a  out  DATA_WIDTH  registered operand A to ALU.
- o_alu_b  out  DATA_WIDTH  registered operand B to ALU.
- o_alu_op  out  OP_WIDTH  registered opcode to ALU.
- i_alu_result  in  DATA_WIDTH  combinational ALU result.
- i_alu_flags  in  3  {negative, zero, carry} from ALU.
- o_busy  out  1  high in every state except WAIT_A.
- o_drop  out  1  one-cycle pulse: received byte discarded.
- o_timeout  out  1  one-cycle pulse: partial command abandoned.

## Operation

- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, SEND_FLG.
- WAIT_A: on i_rx_valid, o_alu_a <= i_rx_data, go WAIT_B.
- WAIT_B: on i_rx_valid, o_alu_b <= i_rx_data, go WAIT_OP.
- WAIT_OP: on i_rx_valid, byte checked against valid set {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL}; bits above OP_WIDTH-1 must be zero. Valid: o_alu_op <= i_rx_data[OP_WIDTH-1:0], err <= 0. Invalid: o_alu_op unchanged, err <= 1. Go EXEC.
- EXEC (one cycle): valid → res_q <= i_alu_result, flg_q <= {5'b0, i_alu_flags}; err → res_q <= 0, flg_q <= 8'h80. Go SEND_RES.
- SEND_RES: o_tx_valid=1, o_tx_data=res_q; on i_tx_ready go SEND_FLG.
- SEND_FLG: o_tx_valid=1, o_tx_data=flg_q; on i_tx_ready go WAIT_A.
- o_alu_a/b/op hold their values after the command completes (still visible on LEDs) until overwritten by the next command.
- i_rx_valid in EXEC, SEND_RES or SEND_FLG: byte ignored, o_drop pulses the following cycle.
- Timeout: counter cleared on each accepted byte and on entry to WAIT_A; counts only in WAIT_B/WAIT_OP. Reaching TIMEOUT_CYCLES-1 without i_rx_valid → go WAIT_A, o_timeout pulses the next cycle; captured A/B retained on outputs. A byte arriving in the same cycle as expiry is accepted (byte wins).

## Timing

- Reset (async assert, sync release): state WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_valid, o_busy, o_drop, o_timeout = 0; timeout counter 0.
- Reset mid-command or mid-response aborts with no further tx byte.
- Opcode byte accepted at edge t → EXEC during cycle t+1 → o_tx_valid high from t+2.
- o_tx_data stable while o_tx_valid high; valid never drops without a handshake.
- Back-to-back: with i_tx_ready held high, result transfers at t+2, flags at t+3, WAIT_A at t+4; a byte at t+4 is accepted as A.
- o_busy combinational from state (or registered equivalently, same-cycle).

## Test plan

- Reset, send 0x05, 0x03, 0x20, i_tx_ready=1 → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; tx bytes 0x08 then flags from model (0x00); o_tx_valid first at op-edge+2.
- Send 0x01, 0x02, 0x22 (SUB); model ALU gives 0xFF, flags negative → tx 0xFF, 0x04; back-to-back command immediately after is accepted.
- Send 0x10, 0x10, 0x3F → tx 0x00, 0x80; o_alu_op keeps previous value.
- Hold i_tx_ready=0 for 10 cycles in SEND_RES, pulse rx bytes meanwhile → o_tx_data stays result, o_drop pulses per byte, then both bytes delivered in order.
- TIMEOUT_CYCLES=16: send A only, wait 16 cycles → o_timeout one pulse, state WAIT_A; next 3 bytes form a fresh command correctly.
- Assert i_rst_n low in SEND_FLG → all outputs 0 immediately; after release, new command completes normally.
